// File: rtl/port_change_monitor_if.sv
// port_change_monitor_if: event record stream from the monitor FIFO head to its consumer
interface port_change_monitor_if #(parameter int NCHAN = 4, parameter int WIDTH = 8);
    localparam int CW = NCHAN > 1 ? $clog2(NCHAN) : 1;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_chan;
    logic [WIDTH-1:0] out_value;
    modport master (output out_valid, out_chan, out_value, input out_ready);
    modport slave  (input out_valid, out_chan, out_value, output out_ready);
endinterface

// File: rtl/port_change_monitor.sv
// port_change_monitor: per-channel change detect, coalescing pending store, round-robin arbiter
// and show-ahead event FIFO.
module port_change_monitor #(
    parameter int NCHAN = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW = NCHAN > 1 ? $clog2(NCHAN) : 1,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCHAN*WIDTH-1:0] din,
    input  logic [NCHAN-1:0]       chan_en,
    port_change_monitor_if.master  evt,
    output logic [LW-1:0]          level,
    output logic [15:0]            coalesce_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic             primed;
    logic [WIDTH-1:0] prev [NCHAN];
    logic [WIDTH-1:0] pval [NCHAN];
    logic [NCHAN-1:0] pending, chg, elig;
    logic [CW-1:0]    ptr, sel, idx;
    logic             found, pop, push;
    logic [4:0]       ncoal;
    logic [16:0]      csum;
    logic [CW+WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;

    // disabled channels are masked from arbitration so their pending event is dropped
    always_comb begin
        ncoal = '0;
        found = 1'b0;
        sel = '0;
        idx = '0;
        for (int i = 0; i < NCHAN; i++) begin
            chg[i] = primed && chan_en[i] && din[i*WIDTH +: WIDTH] != prev[i];
            elig[i] = pending[i] && chan_en[i];
        end
        for (int k = 0; k < NCHAN; k++) begin
            idx = CW'((int'(ptr) + k) % NCHAN);
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel = idx;
            end
        end
        pop = evt.out_valid && evt.out_ready;
        push = found && (level < LW'(DEPTH) || pop);
        for (int i = 0; i < NCHAN; i++)
            ncoal = ncoal + 5'(chg[i] && pending[i] && !(push && sel == CW'(i)));
        csum = 17'(coalesce_cnt) + 17'(ncoal);
    end

    assign evt.out_valid = level != '0;
    assign {evt.out_chan, evt.out_value} = evt.out_valid ? mem[rp] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed <= 1'b0;
            pending <= '0;
            ptr <= '0;
            wp <= '0;
            rp <= '0;
            level <= '0;
            coalesce_cnt <= '0;
            for (int i = 0; i < NCHAN; i++) begin
                prev[i] <= '0;
                pval[i] <= '0;
            end
        end else begin
            primed <= 1'b1;
            for (int i = 0; i < NCHAN; i++) begin
                prev[i] <= din[i*WIDTH +: WIDTH];
                if (!chan_en[i])
                    pending[i] <= 1'b0;
                else if (chg[i]) begin
                    pending[i] <= 1'b1;
                    pval[i] <= din[i*WIDTH +: WIDTH];
                end else if (push && sel == CW'(i))
                    pending[i] <= 1'b0;
            end
            coalesce_cnt <= csum > 17'hFFFF ? 16'hFFFF : csum[15:0];
            if (push) begin
                wp <= wp + 1'b1;
                ptr <= sel == CW'(NCHAN - 1) ? '0 : sel + 1'b1;
            end
            if (pop)
                rp <= rp + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk)
        if (push)
            mem[wp] <= {sel, pval[sel]};
endmodule

// File: doc/port_change_monitor.md
Name: port_change_monitor

Overview:
- Multi-channel change monitor for simulation and debug. It samples NCHAN input buses every clock and turns each value change into an event record {channel, new value}.
- Events are coalesced per channel, arbitrated round-robin and buffered in a FIFO that drains over a valid/ready interface.
- It is the clocked, parametrised successor to the per-module $display port monitors used in the instance transformation testcases.
- Unconnected or disabled channels produce no events.

Parameters:
- NCHAN, 4, number of monitored channels (1..16).
- WIDTH, 8, bits per channel.
- DEPTH, 8, event FIFO entries (power of two, ≥2).
- CW, $clog2(NCHAN) with minimum 1, channel index width (localparam).
- LW, $clog2(DEPTH+1), level width (localparam).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  NCHAN*WIDTH  channel i occupies din[i*WIDTH +: WIDTH].
- chan_en  input  NCHAN  per-channel event enable.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head.
- out_chan  output  CW  channel index of the head record.
- out_value  output  WIDTH  value of the head record.
- level  output  LW  current FIFO occupancy.
- coalesce_cnt  output  16  count of overwritten pending events; saturates.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_chan=0, out_value=0, level=0, coalesce_cnt=0.
  - Pending flags cleared; round-robin pointer=0; primed=0.
- Priming:
  - The first clock after reset release loads prev[i]=din[i] for all i and sets primed=1.
  - No events are raised on that cycle.
- Change detect (primed=1): chg[i] = chan_en[i] && (din[i] != prev[i]).
  - prev[i] loads din[i] every cycle, regardless of chan_en.
- Pending store: one flag and one value register per channel.
  - chg[i] with pending[i]=0: pending[i]=1, pval[i]=din[i].
  - chg[i] with pending[i]=1 and i not pushed this cycle: pval[i]=din[i]; coalesce_cnt+1, saturating at 0xFFFF.
  - chg[i] with i pushed this cycle: the old pval is pushed, pending[i] stays 1, pval[i]=din[i]; no coalesce count.
  - chan_en[i]=0 clears pending[i] next cycle without counting.
- Arbiter:
  - Selects the first pending channel at index ≥ptr, wrapping modulo NCHAN.
  - Pushes {sel, pval[sel]} when push is allowed, then clears pending[sel] (subject to the re-change rule above); ptr = (sel+1) mod NCHAN.
  - Maximum one push per cycle; ptr is unchanged when nothing is pushed.
- FIFO: show-ahead.
  - out_valid = (level != 0); out_chan/out_value are the head entry and hold stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready.
  - Push is allowed when level < DEPTH, or level == DEPTH with a pop in the same cycle. Simultaneous push and pop leaves level unchanged.
  - When the FIFO is full and not popping, pending flags persist; nothing is lost beyond coalescing.
  - Pointers wrap modulo DEPTH.
- Latency: din change sampled at edge t → pending at t+1 → pushed at t+2 edge → out_valid high after edge t+2, when the FIFO has space and no higher-priority channel is pending.
- Pop with out_valid=0 is ignored. out_ready is don't-care when empty.
- Reset asserted mid-operation clears all state immediately; the first post-reset cycle re-primes.

Test Plan:
- Reset release with din=32'h07060504 held → no events ever; level=0, out_valid=0, coalesce_cnt=0.
- Channel 1 changes 05→2A once, out_ready=1 → exactly one record {chan=1, value=8'h2A}; out_valid is high for one cycle, 2 cycles after the change edge.
- Channels 0, 2, 3 change on the same cycle, out_ready=1 → records arrive in order chan 0, 2, 3 on consecutive cycles; a subsequent simultaneous change on 0 and 3 outputs 0, then 3 (ptr=0 after wrapping).
- out_ready=0, channel 0 toggles through 10 distinct values at one per cycle (NCHAN=4, DEPTH=8) → the FIFO absorbs the pushes and then stalls with level=8 and pending set; coalesce_cnt counts each overwrite of pending; with out_ready=1, records drain in order ending with the last value; no record is duplicated.
- chan_en=4'b1011 while channel 2 toggles → no chan-2 records. Clearing chan_en[0] while channel 0 is pending drops that event; coalesce_cnt is unchanged.
- rst_n asserted with level=5 and pending set → all outputs return to 0 immediately. After release, a din that differed before reset produces no event on the priming cycle.
